// File: rtl/feistel_cipher_iter_if.sv
// Request/result bundle for feistel_cipher_iter: start/mode/block/key in,
// busy/end/result out.
interface feistel_cipher_iter_if #(
    parameter int BLOCK_W = 128
);
    logic                   encrypt_start;
    logic                   decrypt;
    logic [BLOCK_W-1:0]     Plain;
    logic [BLOCK_W/2-1:0]   Key;
    logic                   busy;
    logic                   encrypt_end;
    logic [BLOCK_W-1:0]     Cipher;

    modport master (
        output encrypt_start, decrypt, Plain, Key,
        input  busy, encrypt_end, Cipher
    );

    modport slave (
        input  encrypt_start, decrypt, Plain, Key,
        output busy, encrypt_end, Cipher
    );
endinterface

// File: rtl/feistel_cipher_iter.sv
// Iterative Feistel cipher, one round per clock, IDLE -> RUN -> DONE handshake.
// Define FEISTEL_DECRYPT_EN to honour the decrypt input; otherwise all ops encrypt.
module feistel_cipher_iter #(
    parameter int BLOCK_W = 128,
    parameter int ROUNDS  = 32,
    parameter int ROT_A   = 1,
    parameter int ROT_B   = 8,
    parameter int ROT_C   = 2
) (
    input  logic               clock,
    input  logic               reset,
    feistel_cipher_iter_if.slave bus
);
    localparam int H = BLOCK_W / 2;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t         state;
    logic [H-1:0]   l, r, key;
    logic [7:0]     cnt;
    logic [7:0]     kidx;
    logic [H-1:0]   rk, nl, nr;

    function automatic logic [H-1:0] rotl(input logic [H-1:0] x, input int n);
        int s;
        s = n % H;
        return (x << s) | (x >> (H - s));
    endfunction

    function automatic logic [H-1:0] f_round(input logic [H-1:0] x, input logic [H-1:0] k);
        return (rotl(x, ROT_A) & rotl(x, ROT_B)) ^ rotl(x, ROT_C) ^ k;
    endfunction

`ifdef FEISTEL_DECRYPT_EN
    logic dec;

    // Decrypt walks the key schedule backwards and mirrors the half swap.
    always_comb begin
        kidx = dec ? (8'(ROUNDS - 1) - cnt) : cnt;
        rk   = key ^ H'(kidx);
        if (dec) begin
            nr = l;
            nl = r ^ f_round(l, rk);
        end else begin
            nl = r;
            nr = l ^ f_round(r, rk);
        end
    end
`else
    logic unused_decrypt;
    assign unused_decrypt = bus.decrypt;

    always_comb begin
        kidx = cnt;
        rk   = key ^ H'(kidx);
        nl   = r;
        nr   = l ^ f_round(r, rk);
    end
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            state           <= IDLE;
            l               <= '0;
            r               <= '0;
            key             <= '0;
            cnt             <= '0;
            bus.busy        <= 1'b0;
            bus.encrypt_end <= 1'b0;
            bus.Cipher      <= '0;
`ifdef FEISTEL_DECRYPT_EN
            dec             <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (bus.encrypt_start) begin
                        l        <= bus.Plain[BLOCK_W-1:H];
                        r        <= bus.Plain[H-1:0];
                        key      <= bus.Key;
                        cnt      <= '0;
                        bus.busy <= 1'b1;
                        state    <= RUN;
`ifdef FEISTEL_DECRYPT_EN
                        dec      <= bus.decrypt;
`endif
                    end
                end
                RUN: begin
                    l   <= nl;
                    r   <= nr;
                    cnt <= cnt + 8'd1;
                    if (cnt == 8'(ROUNDS - 1)) begin
                        bus.Cipher      <= {nl, nr};
                        bus.encrypt_end <= 1'b1;
                        state           <= DONE;
                    end
                end
                DONE: begin
                    bus.encrypt_end <= 1'b0;
                    bus.busy        <= 1'b0;
                    state           <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_feistel_cipher_iter.sv
// Randomized self-checking bench for feistel_cipher_iter against a loop-level
// Feistel model; three instances cover ROUNDS = 1, 2 and 32.
module tb_feistel_cipher_iter;
    localparam int BW = 128;
    localparam int H  = BW / 2;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int n_vec = 0;
    int n_err = 0;

    logic          st [3];
    logic          dm [3];
    logic [BW-1:0] pl [3];
    logic [H-1:0]  ky [3];
    logic          bz [3];
    logic          en [3];
    logic [BW-1:0] cp [3];

    feistel_cipher_iter_if #(.BLOCK_W(BW)) if0 ();
    feistel_cipher_iter_if #(.BLOCK_W(BW)) if1 ();
    feistel_cipher_iter_if #(.BLOCK_W(BW)) if2 ();

    feistel_cipher_iter #(.BLOCK_W(BW), .ROUNDS(1))  dut0 (.clock(clock), .reset(reset), .bus(if0));
    feistel_cipher_iter #(.BLOCK_W(BW), .ROUNDS(2))  dut1 (.clock(clock), .reset(reset), .bus(if1));
    feistel_cipher_iter #(.BLOCK_W(BW), .ROUNDS(32)) dut2 (.clock(clock), .reset(reset), .bus(if2));

    assign if0.encrypt_start = st[0]; assign if0.decrypt = dm[0];
    assign if0.Plain = pl[0];         assign if0.Key = ky[0];
    assign if1.encrypt_start = st[1]; assign if1.decrypt = dm[1];
    assign if1.Plain = pl[1];         assign if1.Key = ky[1];
    assign if2.encrypt_start = st[2]; assign if2.decrypt = dm[2];
    assign if2.Plain = pl[2];         assign if2.Key = ky[2];
    assign bz[0] = if0.busy; assign en[0] = if0.encrypt_end; assign cp[0] = if0.Cipher;
    assign bz[1] = if1.busy; assign en[1] = if1.encrypt_end; assign cp[1] = if1.Cipher;
    assign bz[2] = if2.busy; assign en[2] = if2.encrypt_end; assign cp[2] = if2.Cipher;

    // Reference model: bit-position rotate, then the Feistel rules round by round.
    function automatic logic [H-1:0] m_rotl(input logic [H-1:0] x, input int n);
        logic [H-1:0] y;
        for (int b = 0; b < H; b++) y[(b + n) % H] = x[b];
        return y;
    endfunction

    function automatic logic [H-1:0] m_f(input logic [H-1:0] x, input logic [H-1:0] k);
        return (m_rotl(x, 1) & m_rotl(x, 8)) ^ m_rotl(x, 2) ^ k;
    endfunction

    function automatic logic [BW-1:0] m_enc(input logic [BW-1:0] p, input logic [H-1:0] k, input int rounds);
        logic [H-1:0] lh, rh, t;
        lh = p[BW-1:H]; rh = p[H-1:0];
        for (int i = 0; i < rounds; i++) begin
            t  = lh ^ m_f(rh, k ^ H'(i));
            lh = rh;
            rh = t;
        end
        return {lh, rh};
    endfunction

    function automatic logic [BW-1:0] m_dec(input logic [BW-1:0] p, input logic [H-1:0] k, input int rounds);
        logic [H-1:0] lh, rh, t;
        lh = p[BW-1:H]; rh = p[H-1:0];
        for (int i = 0; i < rounds; i++) begin
            t  = rh ^ m_f(lh, k ^ H'(rounds - 1 - i));
            rh = lh;
            lh = t;
        end
        return {lh, rh};
    endfunction

    function automatic logic [BW-1:0] rnd_blk();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Launch one op; lat = edges from start-sample to end-visible cycle.
    task automatic run_op(input int d, input logic [BW-1:0] p, input logic [H-1:0] k, input logic m,
                          output logic [BW-1:0] res, output int lat, output int bcnt);
        bit got;
        got = 0; res = '0; lat = -1; bcnt = 0;
        @(negedge clock);
        pl[d] = p; ky[d] = k; dm[d] = m; st[d] = 1'b1;
        for (int c = 1; c <= 400 && !got; c++) begin
            @(negedge clock);
            if (bz[d]) bcnt++;
            if (en[d]) begin
                got = 1; lat = c - 1; res = cp[d]; st[d] = 1'b0;
            end
        end
        if (!got) begin
            n_vec++; n_err++;
            $display("FAIL run_op_timeout dut%0d: no encrypt_end within 400 cycles", d);
        end else begin
            @(negedge clock);
            if (bz[d]) bcnt++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        for (int d = 0; d < 3; d++) begin
            st[d] = 1'b0; dm[d] = 1'b0; pl[d] = '0; ky[d] = '0;
        end
        repeat (3) @(negedge clock);
        for (int d = 0; d < 3; d++) begin
            n_vec++; if (bz[d] !== 1'b0) begin n_err++; $display("FAIL reset_busy dut%0d: got %b want 0", d, bz[d]); end
            n_vec++; if (en[d] !== 1'b0) begin n_err++; $display("FAIL reset_end dut%0d: got %b want 0", d, en[d]); end
            n_vec++; if (cp[d] !== '0)   begin n_err++; $display("FAIL reset_cipher dut%0d: got %h want 0", d, cp[d]); end
        end
        reset = 1'b0;
    endtask

    task automatic test_one_round();
        logic [BW-1:0] res; int lat, bc;
        run_op(0, '1, '0, 1'b0, res, lat, bc);
        n_vec++; if (lat !== 1)   begin n_err++; $display("FAIL r1_latency: got %0d want 1", lat); end
        n_vec++; if (res !== '1)  begin n_err++; $display("FAIL r1_cipher: got %h want all-ones", res); end
        n_vec++; if (bc !== 2)    begin n_err++; $display("FAIL r1_busy_cycles: got %0d want 2", bc); end
    endtask

    task automatic test_two_rounds();
        logic [BW-1:0] res, exp; int lat, bc;
        exp = {{(BW-8){1'b1}}, 8'hFE};
        run_op(1, '1, '0, 1'b0, res, lat, bc);
        n_vec++; if (lat !== 2)   begin n_err++; $display("FAIL r2_latency: got %0d want 2", lat); end
        n_vec++; if (res !== exp) begin n_err++; $display("FAIL r2_cipher: got %h want %h", res, exp); end
        n_vec++; if (bc !== 3)    begin n_err++; $display("FAIL r2_busy_cycles: got %0d want 3", bc); end
    endtask

    task automatic test_roundtrip();
        logic [BW-1:0] p, c, back, exp2; logic [H-1:0] k; int lat, bc;
        for (int n = 0; n < 100; n++) begin
            p = rnd_blk(); k = {$urandom, $urandom};
            run_op(2, p, k, 1'b0, c, lat, bc);
            n_vec++; if (c !== m_enc(p, k, 32)) begin n_err++; $display("FAIL rt_encrypt #%0d: got %h want %h", n, c, m_enc(p, k, 32)); end
            n_vec++; if (lat !== 32) begin n_err++; $display("FAIL rt_latency #%0d: got %0d want 32", n, lat); end
            run_op(2, c, k, 1'b1, back, lat, bc);
`ifdef FEISTEL_DECRYPT_EN
            exp2 = m_dec(c, k, 32);
            n_vec++; if (back !== p) begin n_err++; $display("FAIL rt_recover #%0d: got %h want %h", n, back, p); end
`else
            exp2 = m_enc(c, k, 32);
            if (exp2 != p) begin
                n_vec++; if (back === p) begin n_err++; $display("FAIL rt_no_decrypt #%0d: got %h want not %h", n, back, p); end
            end
`endif
            n_vec++; if (back !== exp2) begin n_err++; $display("FAIL rt_second_pass #%0d: got %h want %h", n, back, exp2); end
        end
    endtask

    task automatic test_ignore_start();
        logic [BW-1:0] p0, res; logic [H-1:0] k0; int ends;
        p0 = rnd_blk(); k0 = {$urandom, $urandom}; ends = 0; res = '0;
        @(negedge clock);
        pl[2] = p0; ky[2] = k0; dm[2] = 1'b0; st[2] = 1'b1;
        @(negedge clock);
        st[2] = 1'b0;
        repeat (5) @(negedge clock);
        st[2] = 1'b1; pl[2] = rnd_blk(); ky[2] = {$urandom, $urandom}; dm[2] = 1'b1;
        repeat (5) @(negedge clock);
        st[2] = 1'b0; pl[2] = rnd_blk();
        for (int c = 0; c < 60; c++) begin
            @(negedge clock);
            if (en[2]) begin ends++; res = cp[2]; end
        end
        n_vec++; if (ends !== 1) begin n_err++; $display("FAIL ign_end_count: got %0d want 1", ends); end
        n_vec++; if (res !== m_enc(p0, k0, 32)) begin n_err++; $display("FAIL ign_cipher: got %h want %h", res, m_enc(p0, k0, 32)); end
    endtask

    task automatic test_back_to_back();
        logic [BW-1:0] p; logic [H-1:0] k; int e [3]; int ne;
        p = rnd_blk(); k = {$urandom, $urandom}; ne = 0;
        e[0] = 0; e[1] = 0; e[2] = 0;
        @(negedge clock);
        pl[2] = p; ky[2] = k; dm[2] = 1'b0; st[2] = 1'b1;
        for (int c = 0; c < 200 && ne < 3; c++) begin
            @(negedge clock);
            if (en[2]) begin
                e[ne] = cyc; ne++;
                if (ne == 1) begin
                    n_vec++; if (cp[2] !== m_enc(p, k, 32)) begin n_err++; $display("FAIL b2b_cipher: got %h want %h", cp[2], m_enc(p, k, 32)); end
                end
                if (ne == 3) st[2] = 1'b0;
            end
        end
        st[2] = 1'b0;
        n_vec++; if (ne !== 3) begin n_err++; $display("FAIL b2b_pulses: got %0d want 3", ne); end
        n_vec++; if (e[1] - e[0] !== 34) begin n_err++; $display("FAIL b2b_spacing1: got %0d want 34", e[1] - e[0]); end
        n_vec++; if (e[2] - e[1] !== 34) begin n_err++; $display("FAIL b2b_spacing2: got %0d want 34", e[2] - e[1]); end
        repeat (3) @(negedge clock);
    endtask

    task automatic test_reset_midrun();
        logic [BW-1:0] p, res; logic [H-1:0] k; int ends, lat, bc;
        p = rnd_blk(); k = {$urandom, $urandom}; ends = 0;
        @(negedge clock);
        pl[2] = p; ky[2] = k; dm[2] = 1'b0; st[2] = 1'b1;
        repeat (11) @(negedge clock);
        n_vec++; if (bz[2] !== 1'b1) begin n_err++; $display("FAIL mid_busy_before: got %b want 1", bz[2]); end
        st[2] = 1'b0; reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        n_vec++; if (bz[2] !== 1'b0) begin n_err++; $display("FAIL mid_busy: got %b want 0", bz[2]); end
        n_vec++; if (cp[2] !== '0)   begin n_err++; $display("FAIL mid_cipher: got %h want 0", cp[2]); end
        n_vec++; if (en[2] !== 1'b0) begin n_err++; $display("FAIL mid_end: got %b want 0", en[2]); end
        for (int c = 0; c < 40; c++) begin
            @(negedge clock);
            if (en[2]) ends++;
        end
        n_vec++; if (ends !== 0) begin n_err++; $display("FAIL mid_stray_end: got %0d want 0", ends); end
        run_op(2, p, k, 1'b0, res, lat, bc);
        n_vec++; if (lat !== 32) begin n_err++; $display("FAIL mid_restart_latency: got %0d want 32", lat); end
        n_vec++; if (res !== m_enc(p, k, 32)) begin n_err++; $display("FAIL mid_restart_cipher: got %h want %h", res, m_enc(p, k, 32)); end
    endtask

    initial begin
        test_reset();
        test_one_round();
        test_two_rounds();
        test_roundtrip();
        test_ignore_start();
        test_back_to_back();
        test_reset_midrun();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
